alu_cmd_sequencer: RTL and testbench

Initiator-side companion to the 4-bit ALU port. It buffers 8-bit ALU command words, drives them one at a time onto the ALU's 8-bit operand/opcode input, and waits a fixed settle time. It then captures the ALU's 8-bit result/flag word and returns it over a valid/ready response channel. It sits between the host-side command source and the combinational ALU, and can optionally self-check every returned word against an internal reference model.

---
 rtl/alu_cmd_sequencer_if.sv | 24 ++
 rtl/alu_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Handshake and ALU bus bundle between the command sequencer and its host/ALU.
// The master modport is the sequencer; the slave modport is the host/ALU side.
interface alu_cmd_sequencer_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] alu_cmd;
    logic [7:0] alu_rsp;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       busy;
    logic       mismatch;

    modport master (
        input  cmd_data, cmd_valid, alu_rsp, rsp_ready,
        output cmd_ready, alu_cmd, rsp_data, rsp_valid, busy, mismatch
    );

    modport slave (
        output cmd_data, cmd_valid, alu_rsp, rsp_ready,
        input  cmd_ready, alu_cmd, rsp_data, rsp_valid, busy, mismatch
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU command words, drives them to the ALU, and returns the settled result word.
// Optional self-check of every captured word is built when ALU_SEQ_CHECK_EN is defined.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_sequencer_if.master  bus
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         PW        = AW + 1;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [1:0]    state_r;
    logic [3:0]    cnt_r;
    logic [7:0]    alu_cmd_r;
    logic [7:0]    rsp_data_r;
    logic          rsp_valid_r;

    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          capture_s;
    logic [7:0]    head_s;

    // The extra pointer MSB separates full from empty when the index bits match.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_s  = bus.cmd_valid && !full_s;
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

    // Pop decision: from IDLE whenever data waits, from HOLD only on a response handshake.
    always_comb begin
        pop_s     = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE:   pop_s     = !empty_s;
            ST_SETTLE: capture_s = (cnt_r <= 4'd1);
            ST_HOLD:   pop_s     = !empty_s && rsp_valid_r && bus.rsp_ready;
            default: begin
                pop_s     = 1'b0;
                capture_s = 1'b0;
            end
        endcase
    end

    // Command buffer storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= bus.cmd_data;
                wr_ptr_r                <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Sequencing FSM: drive command, wait the settle time, capture and hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            alu_cmd_r   <= 8'h00;
            rsp_data_r  <= 8'h00;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        alu_cmd_r <= head_s;
                        cnt_r     <= SETTLE_LD;
                        state_r   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (capture_s) begin
                        rsp_data_r  <= bus.alu_rsp;
                        rsp_valid_r <= 1'b1;
                        cnt_r       <= 4'd0;
                        state_r     <= ST_HOLD;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_valid_r && bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if (pop_s) begin
                            alu_cmd_r <= head_s;
                            cnt_r     <= SETTLE_LD;
                            state_r   <= ST_SETTLE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    cnt_r       <= 4'd0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    // Reference ALU: opcodes ADD, SUB, AND, OR, XOR, NOT, SHL, SHR; bit4 carry/borrow.
    function automatic logic [7:0] alu_ref(input logic [7:0] cmd);
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
        a = cmd[3:0];
        b = {3'b000, cmd[4]};
        case (cmd[7:5])
            3'd0:    s = {1'b0, a} + {1'b0, b};
            3'd1:    s = {1'b0, a} - {1'b0, b};
            3'd2:    s = {1'b0, a & b};
            3'd3:    s = {1'b0, a | b};
            3'd4:    s = {1'b0, a ^ b};
            3'd5:    s = {1'b0, ~a};
            3'd6:    s = {1'b0, a[2:0], 1'b0};
            3'd7:    s = {2'b00, a[3:1]};
            default: s = 5'd0;
        endcase
        return {2'b00, (s[3:0] == 4'd0), s[4], s[3:0]};
    endfunction

    logic mismatch_r;

    // Sticky flag: any captured word that disagrees with the reference model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_r <= 1'b0;
        end else if (capture_s && (bus.alu_rsp != alu_ref(alu_cmd_r))) begin
            mismatch_r <= 1'b1;
        end else begin
            mismatch_r <= mismatch_r;
        end
    end

    assign bus.mismatch = mismatch_r;
`else
    assign bus.mismatch = 1'b0;
`endif

    assign bus.cmd_ready = !full_s;
    assign bus.alu_cmd   = alu_cmd_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.busy      = (state_r != ST_IDLE) || !empty_s;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a behavioural ALU answers alu_cmd, and expected
// responses are queued at push time and compared at each response handshake.
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst_n;
    logic corrupt;
    int   n_vec;
    int   n_err;
    int   cyc;
    logic [7:0] sb [$];
    int         hs_cyc [$];

`ifdef ALU_SEQ_CHECK_EN
    localparam logic [7:0] MIS_EXP = 8'd1;
`else
    localparam logic [7:0] MIS_EXP = 8'd0;
`endif

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU; op order ADD SUB AND OR XOR NOT SHL SHR.
    function automatic logic [7:0] alu_model(input logic [7:0] c);
        int a, b, r, cy;
        a  = int'(c[3:0]);
        b  = int'(c[4]);
        cy = 0;
        case (c[7:5])
            3'd0: begin r = a + b; cy = (r > 15) ? 1 : 0; end
            3'd1: begin r = a - b; cy = (r < 0) ? 1 : 0; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 15 - a;
            3'd6: r = a * 2;
            3'd7: r = a / 2;
            default: r = 0;
        endcase
        r = r & 15;
        return 8'((r == 0 ? 32 : 0) + cy * 16 + r);
    endfunction

    function automatic logic [7:0] exp_rsp(input logic [7:0] c);
        return (corrupt && c == 8'h1F) ? 8'h00 : alu_model(c);
    endfunction

    assign bus.alu_rsp = exp_rsp(bus.alu_cmd);

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        int n;
        n = 0;
        bus.cmd_data  = w;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("push_ready", {7'd0, bus.cmd_ready}, 8'd1);
        if (bus.cmd_ready) sb.push_back(exp_rsp(w));
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check_eq("drain", 8'(sb.size()), 8'd0);
        tick();
    endtask

    // Response monitor: each handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            check_eq("rsp_pending", 8'(sb.size() != 0), 8'd1);
            if (sb.size() != 0) check_eq("rsp_data", bus.rsp_data, sb.pop_front());
            hs_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fw [6];
        int accepted, seen;
        fw = '{8'h01, 8'h52, 8'h67, 8'h9C, 8'hE8, 8'h30};
        n_vec = 0; n_err = 0; cyc = 0;
        corrupt = 1'b0;
        rst_n = 1'b0;
        bus.cmd_data = 8'h00; bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state held with no stimulus
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_cmd", bus.alu_cmd, 8'h00);
            check_eq("idle_flags", {4'd0, bus.rsp_valid, bus.cmd_ready, bus.busy, bus.mismatch}, 8'h04);
        end

        // Single command latency: push, pop, then valid one edge later
        push_word(8'h1F);
        check_eq("lat_push_cmd", bus.alu_cmd, 8'h00);
        check_eq("lat_push_flags", {6'd0, bus.busy, bus.rsp_valid}, 8'h02);
        tick();
        check_eq("lat_pop_cmd", bus.alu_cmd, 8'h1F);
        check_eq("lat_pop_valid", {7'd0, bus.rsp_valid}, 8'd0);
        tick();
        check_eq("lat_cap_valid", {7'd0, bus.rsp_valid}, 8'd1);
        check_eq("lat_cap_data", bus.rsp_data, 8'h30);
        bus.rsp_ready = 1'b1;
        wait_drain(20);

        // Back-to-back stream with consumer always ready
        hs_cyc.delete();
        push_word(8'h30);
        push_word(8'hA5);
        push_word(8'hC9);
        wait_drain(40);
        check_eq("stream_count", 8'(hs_cyc.size()), 8'd3);
        if (hs_cyc.size() == 3) begin
            check_eq("stream_gap1", 8'(hs_cyc[1] - hs_cyc[0]), 8'd2);
            check_eq("stream_gap2", 8'(hs_cyc[2] - hs_cyc[1]), 8'd2);
        end
        check_eq("stream_mismatch", {7'd0, bus.mismatch}, 8'd0);

        // Back-pressure: one in flight plus FIFO_DEPTH queued, then refused
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_data  = fw[i];
            bus.cmd_valid = 1'b1;
            if (bus.cmd_ready) begin
                sb.push_back(exp_rsp(fw[i]));
                accepted++;
            end
            tick();
        end
        check_eq("full_accepted", 8'(accepted), 8'd5);
        check_eq("full_ready", {7'd0, bus.cmd_ready}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("hold_data", bus.rsp_data, 8'h01);
            check_eq("hold_cmd", bus.alu_cmd, 8'h01);
            check_eq("hold_ready", {7'd0, bus.cmd_ready}, 8'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain(60);

        // Mid-operation reset while in SETTLE with three words queued
        bus.rsp_ready = 1'b0;
        push_word(8'h23);
        push_word(8'h44);
        push_word(8'h7F);
        push_word(8'h8A);
        bus.cmd_data  = 8'hB3;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        if (bus.cmd_ready) sb.push_back(exp_rsp(8'hB3));
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        check_eq("pre_rst_cmd", bus.alu_cmd, 8'h44);
        check_eq("pre_rst_flags", {6'd0, bus.busy, bus.rsp_valid}, 8'h02);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_eq("rst_cmd", bus.alu_cmd, 8'h00);
        check_eq("rst_data", bus.rsp_data, 8'h00);
        check_eq("rst_flags", {4'd0, bus.rsp_valid, bus.cmd_ready, bus.busy, bus.mismatch}, 8'h04);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rsp_valid || bus.busy) seen++;
        end
        check_eq("post_rst_quiet", 8'(seen), 8'd0);

        // Faulty ALU answer for 0x1F; mismatch is sticky when the checker is built
        corrupt = 1'b1;
        push_word(8'h1F);
        wait_drain(20);
        check_eq("mismatch_set", {7'd0, bus.mismatch}, MIS_EXP);
        push_word(8'h30);
        wait_drain(20);
        check_eq("mismatch_sticky", {7'd0, bus.mismatch}, MIS_EXP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
